risc_v: RTL and testbench
=========================

RISC_V -- requirements
Module: risc_v

Interface
REQ-001 Parameter DATA_ADDRESS_WIDTH, default 6, data-memory word-address width (64 words).
REQ-002 Parameter CPU_DATA_WIDTH, default 32, datapath, register and memory word width.
REQ-003 Parameter REGISTER_FILE_ADDRESS_WIDTH, default 5, register index width (32 registers).
REQ-004 Port clk, input, 1, single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1, reset; asynchronous, active-high.
REQ-006 There SHALL be no other ports; results are observed through internal storage only.
REQ-007 Hierarchy SHALL expose instance if_stage containing instance instruction_memory with array ram[0:31] of 32-bit words.
REQ-008 Hierarchy SHALL expose instance register_file with array registers[0:31], 32-bit.
REQ-009 Hierarchy SHALL expose instance mem_stage containing instance data_memory with array ram[0:63], 32-bit.
REQ-010 All three arrays SHALL be writable and readable by the testbench via hierarchical reference.

Function
REQ-011 The core SHALL be an in-order 5-stage pipeline (IF, ID, EX, MEM, WB) executing RV32I: ADD SUB AND OR XOR SLL SRL SRA SLT SLTU; ADDI ANDI ORI XORI SLLI SRLI SRAI SLTI SLTIU; LUI; LW; SW; BEQ; BNE.
REQ-012 Any other opcode SHALL execute as a NOP (no register or memory write, PC advances normally).
REQ-013 Instruction fetch SHALL be combinational: instruction = ram[PC[6:2]]; PC SHALL increment by 4 per cycle unless stalled or redirected.
REQ-014 PC SHALL wrap modulo 128 bytes (32 words).
REQ-015 Register reads SHALL see a same-cycle WB write (write-before-read).
REQ-016 registers[0] SHALL read 0 and SHALL never be written.
REQ-017 The EX stage SHALL forward from MEM and WB, with MEM taking priority; forwarding SHALL never apply when the source register is x0.
REQ-018 A load followed immediately by a dependent instruction SHALL stall IF/ID one cycle and insert a bubble into EX.
REQ-019 Branches SHALL resolve in EX with target = branch PC + sign-extended B-immediate.
REQ-020 On a taken branch, the two younger instructions SHALL be flushed to NOPs; not-taken branches SHALL cost no cycles.
REQ-021 Data memory SHALL be word-addressed by ALU result bits [DATA_ADDRESS_WIDTH+1:2]; LW reads combinationally and SW writes on the clock edge.
REQ-022 Address wrap: higher address bits SHALL be ignored; misaligned low bits SHALL be ignored.
REQ-023 Arithmetic SHALL be 32-bit modulo 2^32.
REQ-024 Shift amounts SHALL use bits [4:0] only.
REQ-025 SLT SHALL compare signed; SLTU SHALL compare unsigned; SRA and SRAI SHALL sign-fill.
REQ-026 BEQ x0,x0,0 (0x00000063) SHALL loop in place indefinitely, acting as halt; instructions already in the pipeline SHALL complete.

Reset
REQ-027 While rst=1: PC=0, all pipeline registers hold NOP (0x00000013) with control signals deasserted, and registers[0..31]=0.
REQ-028 Reset SHALL take effect asynchronously and release on the first rising edge after rst falls.
REQ-029 Instruction and data memory contents SHALL NOT be altered by reset.
REQ-030 Reset asserted mid-program SHALL abort all in-flight instructions with no further writes.

Verification
REQ-031 Program ADDI x1,x0,5; ADDI x2,x1,-3; ADD x3,x1,x2; SUB x4,x2,x1, remaining memory NOP, ram[31]=halt, run 200 cycles -> x1=5, x2=2, x3=7, x4=0xFFFFFFFD.
REQ-032 ADDI x1,x0,42; SW x1,8(x0); LW x2,8(x0); ADDI x3,x2,1 (load-use) -> data ram[2]=42, x2=42, x3=43.
REQ-033 ADDI x1,x0,1; BEQ x1,x1,+8; ADDI x2,x0,9; ADDI x3,x0,7 -> x2=0 (flushed), x3=7; BNE x0,x0 falls through.
REQ-034 LUI x5,0x80000; SRAI x6,x5,4; SRLI x7,x5,4; SLT x8,x5,x0; SLTU x9,x5,x0 -> x6=0xF8000000, x7=0x08000000, x8=1, x9=0.
REQ-035 ADDI x0,x0,5 -> x0 stays 0; SW to address 256+4 -> data ram[1] written (wrap).
REQ-036 Assert rst for one cycle mid-run -> all registers 0, PC restarts at 0, memories preserved.

Source files
------------

// File: rtl/risc_v.sv
// Five-stage in-order RV32I subset core: forwarding from MEM/WB, one-cycle load-use stall,
// branches resolved in EX. Instruction, register and data storage are internal arrays.

module instruction_memory (
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [4:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o
);
    logic [31:0] ram [0:31];

    always_ff @(posedge clk_i) begin
        if (we_i) ram[addr_i] <= wdata_i;
    end

    assign rdata_o = ram[addr_i];
endmodule

module if_stage (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [6:0]  target_i,
    output logic [6:0]  pc_o,
    output logic [31:0] instr_o
);
    logic [6:0] pc_q, pc_d;

    // 7-bit PC gives the 128-byte wrap for free
    always_comb begin
        pc_d = pc_q + 7'd4;
        if (redirect_i)   pc_d = target_i;
        else if (stall_i) pc_d = pc_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) pc_q <= '0;
        else       pc_q <= pc_d;
    end

    instruction_memory instruction_memory (
        .clk_i   (clk_i),
        .we_i    (1'b0),
        .addr_i  (pc_q[6:2]),
        .wdata_i (32'h0),
        .rdata_o (instr_o)
    );

    assign pc_o = pc_q;
endmodule

module register_file #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [AW-1:0] raddr1_i,
    input  logic [AW-1:0] raddr2_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata1_o,
    output logic [DW-1:0] rdata2_o
);
    logic [DW-1:0] registers [0:(1<<AW)-1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < (1 << AW); i++) registers[i] <= '0;
        end else if (we_i && waddr_i != '0) begin
            registers[waddr_i] <= wdata_i;
        end
    end

    // write-before-read so ID sees the value WB is retiring this cycle
    always_comb begin
        rdata1_o = registers[raddr1_i];
        rdata2_o = registers[raddr2_i];
        if (raddr1_i == '0)                          rdata1_o = '0;
        else if (we_i && waddr_i == raddr1_i)        rdata1_o = wdata_i;
        if (raddr2_i == '0)                          rdata2_o = '0;
        else if (we_i && waddr_i == raddr2_i)        rdata2_o = wdata_i;
    end
endmodule

module data_memory #(
    parameter int AW = 6,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);
    logic [DW-1:0] ram [0:(1<<AW)-1];

    always_ff @(posedge clk_i) begin
        if (we_i) ram[addr_i] <= wdata_i;
    end

    assign rdata_o = ram[addr_i];
endmodule

module mem_stage #(
    parameter int AW = 6,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);
    data_memory #(.AW(AW), .DW(DW)) data_memory (
        .clk_i   (clk_i),
        .we_i    (we_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .rdata_o (rdata_o)
    );
endmodule

module risc_v #(
    parameter int DATA_ADDRESS_WIDTH          = 6,
    parameter int CPU_DATA_WIDTH              = 32,
    parameter int REGISTER_FILE_ADDRESS_WIDTH = 5
) (
    input logic clk,
    input logic rst
);
    localparam int          XLEN = CPU_DATA_WIDTH;
    localparam int          RAW  = REGISTER_FILE_ADDRESS_WIDTH;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_LUI
    } alu_op_e;

    function automatic alu_op_e f3op(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic [6:0]      fetch_pc;
    logic [31:0]     fetch_instr;
    logic [6:0]      if_id_pc_q;
    logic [31:0]     if_id_instr_q;

    logic            id_ex_reg_we_q, id_ex_mem_re_q, id_ex_mem_we_q;
    logic            id_ex_branch_q, id_ex_bne_q, id_ex_use_imm_q;
    alu_op_e         id_ex_alu_op_q;
    logic [RAW-1:0]  id_ex_rd_q, id_ex_rs1_q, id_ex_rs2_q;
    logic [XLEN-1:0] id_ex_rs1_data_q, id_ex_rs2_data_q, id_ex_imm_q;
    logic [6:0]      id_ex_pc_q;

    logic            ex_mem_reg_we_q, ex_mem_mem_re_q, ex_mem_mem_we_q;
    logic [RAW-1:0]  ex_mem_rd_q;
    logic [XLEN-1:0] ex_mem_alu_q, ex_mem_wdata_q;

    logic            mem_wb_reg_we_q;
    logic [RAW-1:0]  mem_wb_rd_q;
    logic [XLEN-1:0] mem_wb_data_q;

    logic            dec_reg_we, dec_mem_re, dec_mem_we, dec_branch, dec_bne, dec_use_imm;
    alu_op_e         dec_alu_op;
    logic [XLEN-1:0] dec_imm, rf_rdata1, rf_rdata2;
    logic [RAW-1:0]  dec_rd, dec_rs1, dec_rs2;
    logic [XLEN-1:0] fwd_a, fwd_b, op_b, alu_res, dmem_rdata;
    logic            load_use, br_taken, kill;
    logic [6:0]      br_target;

    if_stage if_stage (
        .clk_i      (clk),
        .rst_i      (rst),
        .stall_i    (load_use && !br_taken),
        .redirect_i (br_taken),
        .target_i   (br_target),
        .pc_o       (fetch_pc),
        .instr_o    (fetch_instr)
    );

    assign dec_rd  = RAW'(if_id_instr_q[11:7]);
    assign dec_rs1 = RAW'(if_id_instr_q[19:15]);
    assign dec_rs2 = RAW'(if_id_instr_q[24:20]);

    always_comb begin
        dec_reg_we  = 1'b0;
        dec_mem_re  = 1'b0;
        dec_mem_we  = 1'b0;
        dec_branch  = 1'b0;
        dec_bne     = 1'b0;
        dec_use_imm = 1'b0;
        dec_alu_op  = ALU_ADD;
        dec_imm     = XLEN'($signed(if_id_instr_q[31:20]));
        case (if_id_instr_q[6:0])
            7'b0110011: begin
                dec_reg_we = 1'b1;
                dec_alu_op = f3op(if_id_instr_q[14:12], if_id_instr_q[30]);
            end
            7'b0010011: begin
                dec_reg_we  = 1'b1;
                dec_use_imm = 1'b1;
                dec_alu_op  = f3op(if_id_instr_q[14:12],
                                   if_id_instr_q[14:12] == 3'b101 && if_id_instr_q[30]);
            end
            7'b0110111: begin
                dec_reg_we  = 1'b1;
                dec_use_imm = 1'b1;
                dec_alu_op  = ALU_LUI;
                dec_imm     = XLEN'($signed({if_id_instr_q[31:12], 12'h000}));
            end
            7'b0000011: begin
                dec_reg_we  = 1'b1;
                dec_mem_re  = 1'b1;
                dec_use_imm = 1'b1;
            end
            7'b0100011: begin
                dec_mem_we  = 1'b1;
                dec_use_imm = 1'b1;
                dec_imm     = XLEN'($signed({if_id_instr_q[31:25], if_id_instr_q[11:7]}));
            end
            7'b1100011: begin
                dec_branch = (if_id_instr_q[14:13] == 2'b00);
                dec_bne    = if_id_instr_q[12];
                dec_imm    = XLEN'($signed({if_id_instr_q[31], if_id_instr_q[7],
                                            if_id_instr_q[30:25], if_id_instr_q[11:8], 1'b0}));
            end
            default: ;
        endcase
    end

    register_file #(.AW(RAW), .DW(XLEN)) register_file (
        .clk_i    (clk),
        .rst_i    (rst),
        .raddr1_i (dec_rs1),
        .raddr2_i (dec_rs2),
        .we_i     (mem_wb_reg_we_q),
        .waddr_i  (mem_wb_rd_q),
        .wdata_i  (mem_wb_data_q),
        .rdata1_o (rf_rdata1),
        .rdata2_o (rf_rdata2)
    );

    // conservative: stalls even if the consumer ignores rs2
    assign load_use = id_ex_mem_re_q && id_ex_rd_q != '0 &&
                      (id_ex_rd_q == dec_rs1 || id_ex_rd_q == dec_rs2);

    always_comb begin
        fwd_a = id_ex_rs1_data_q;
        fwd_b = id_ex_rs2_data_q;
        if (id_ex_rs1_q != '0 && ex_mem_reg_we_q && ex_mem_rd_q == id_ex_rs1_q)
            fwd_a = ex_mem_alu_q;
        else if (id_ex_rs1_q != '0 && mem_wb_reg_we_q && mem_wb_rd_q == id_ex_rs1_q)
            fwd_a = mem_wb_data_q;
        if (id_ex_rs2_q != '0 && ex_mem_reg_we_q && ex_mem_rd_q == id_ex_rs2_q)
            fwd_b = ex_mem_alu_q;
        else if (id_ex_rs2_q != '0 && mem_wb_reg_we_q && mem_wb_rd_q == id_ex_rs2_q)
            fwd_b = mem_wb_data_q;
    end

    assign op_b = id_ex_use_imm_q ? id_ex_imm_q : fwd_b;

    always_comb begin
        alu_res = fwd_a + op_b;
        case (id_ex_alu_op_q)
            ALU_SUB:  alu_res = fwd_a - op_b;
            ALU_SLL:  alu_res = fwd_a << op_b[4:0];
            ALU_SLT:  alu_res = XLEN'($signed(fwd_a) < $signed(op_b));
            ALU_SLTU: alu_res = XLEN'(fwd_a < op_b);
            ALU_XOR:  alu_res = fwd_a ^ op_b;
            ALU_SRL:  alu_res = fwd_a >> op_b[4:0];
            ALU_SRA:  alu_res = XLEN'($signed(fwd_a) >>> op_b[4:0]);
            ALU_OR:   alu_res = fwd_a | op_b;
            ALU_AND:  alu_res = fwd_a & op_b;
            ALU_LUI:  alu_res = op_b;
            default:  ;
        endcase
    end

    assign br_taken  = id_ex_branch_q && ((fwd_a == fwd_b) != id_ex_bne_q);
    assign br_target = id_ex_pc_q + id_ex_imm_q[6:0];
    assign kill      = br_taken || load_use;

    mem_stage #(.AW(DATA_ADDRESS_WIDTH), .DW(XLEN)) mem_stage (
        .clk_i   (clk),
        .we_i    (ex_mem_mem_we_q),
        .addr_i  (ex_mem_alu_q[DATA_ADDRESS_WIDTH+1:2]),
        .wdata_i (ex_mem_wdata_q),
        .rdata_o (dmem_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_id_pc_q       <= '0;
            if_id_instr_q    <= NOP;
            id_ex_reg_we_q   <= 1'b0;
            id_ex_mem_re_q   <= 1'b0;
            id_ex_mem_we_q   <= 1'b0;
            id_ex_branch_q   <= 1'b0;
            id_ex_bne_q      <= 1'b0;
            id_ex_use_imm_q  <= 1'b0;
            id_ex_alu_op_q   <= ALU_ADD;
            id_ex_rd_q       <= '0;
            id_ex_rs1_q      <= '0;
            id_ex_rs2_q      <= '0;
            id_ex_rs1_data_q <= '0;
            id_ex_rs2_data_q <= '0;
            id_ex_imm_q      <= '0;
            id_ex_pc_q       <= '0;
            ex_mem_reg_we_q  <= 1'b0;
            ex_mem_mem_re_q  <= 1'b0;
            ex_mem_mem_we_q  <= 1'b0;
            ex_mem_rd_q      <= '0;
            ex_mem_alu_q     <= '0;
            ex_mem_wdata_q   <= '0;
            mem_wb_reg_we_q  <= 1'b0;
            mem_wb_rd_q      <= '0;
            mem_wb_data_q    <= '0;
        end else begin
            if (br_taken) begin
                if_id_instr_q <= NOP;
                if_id_pc_q    <= '0;
            end else if (!load_use) begin
                if_id_instr_q <= fetch_instr;
                if_id_pc_q    <= fetch_pc;
            end
            id_ex_reg_we_q   <= dec_reg_we && !kill;
            id_ex_mem_re_q   <= dec_mem_re && !kill;
            id_ex_mem_we_q   <= dec_mem_we && !kill;
            id_ex_branch_q   <= dec_branch && !kill;
            id_ex_bne_q      <= dec_bne;
            id_ex_use_imm_q  <= dec_use_imm;
            id_ex_alu_op_q   <= dec_alu_op;
            id_ex_rd_q       <= dec_rd;
            id_ex_rs1_q      <= dec_rs1;
            id_ex_rs2_q      <= dec_rs2;
            id_ex_rs1_data_q <= rf_rdata1;
            id_ex_rs2_data_q <= rf_rdata2;
            id_ex_imm_q      <= dec_imm;
            id_ex_pc_q       <= if_id_pc_q;
            ex_mem_reg_we_q  <= id_ex_reg_we_q;
            ex_mem_mem_re_q  <= id_ex_mem_re_q;
            ex_mem_mem_we_q  <= id_ex_mem_we_q;
            ex_mem_rd_q      <= id_ex_rd_q;
            ex_mem_alu_q     <= alu_res;
            ex_mem_wdata_q   <= fwd_b;
            mem_wb_reg_we_q  <= ex_mem_reg_we_q;
            mem_wb_rd_q      <= ex_mem_rd_q;
            mem_wb_data_q    <= ex_mem_mem_re_q ? dmem_rdata : ex_mem_alu_q;
        end
    end
endmodule

// File: tb/tb_risc_v.sv
// Bench for risc_v: small programs preloaded into instruction memory, expected register and
// data-memory contents queued per program and compared after the core halts.

module tb_risc_v;
    localparam int          NPROG = 6;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] HALT  = 32'h0000_0063;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    typedef struct {
        int          prog;
        bit          is_mem;
        int          idx;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[$];
    vec_t        sb[$];
    logic [31:0] pmem [0:NPROG-1][0:31];
    int          plen [0:NPROG-1];

    risc_v dut (.clk(clk), .rst(rst));

    always #5 clk = ~clk;

    function automatic logic [31:0] op_i(input int f3, input int rd, input int rs1, input int imm);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], 7'h13};
    endfunction
    function automatic logic [31:0] op_r(input int f7, input int f3, input int rd, input int rs1, input int rs2);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction
    function automatic logic [31:0] lw(input int rd, input int rs1, input int imm);
        return {imm[11:0], rs1[4:0], 3'b010, rd[4:0], 7'h03};
    endfunction
    function automatic logic [31:0] sw(input int rs2, input int rs1, input int imm);
        return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] br(input int f3, input int rs1, input int rs2, input int imm);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] lui(input int rd, input int imm20);
        return {imm20[19:0], rd[4:0], 7'h37};
    endfunction

    task automatic put(input int p, input logic [31:0] w);
        pmem[p][plen[p]] = w;
        plen[p]++;
    endtask
    task automatic er(input int p, input int idx, input logic [31:0] v);
        vecs.push_back('{prog: p, is_mem: 1'b0, idx: idx, exp: v});
    endtask
    task automatic em(input int p, input int idx, input logic [31:0] v);
        vecs.push_back('{prog: p, is_mem: 1'b1, idx: idx, exp: v});
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h, want %08h", name, act, exp);
        end
    endtask

    task automatic build();
        for (int p = 0; p < NPROG; p++) begin
            plen[p] = 0;
            for (int i = 0; i < 32; i++) pmem[p][i] = NOP;
            pmem[p][31] = HALT;
        end
        put(0, op_i(0, 1, 0, 5));   put(0, op_i(0, 2, 1, -3));
        put(0, op_r(0, 0, 3, 1, 2)); put(0, op_r(32, 0, 4, 2, 1));
        er(0, 1, 5); er(0, 2, 2); er(0, 3, 7); er(0, 4, 32'hFFFF_FFFD); er(0, 0, 0);

        put(1, op_i(0, 1, 0, 42)); put(1, sw(1, 0, 8)); put(1, lw(2, 0, 8)); put(1, op_i(0, 3, 2, 1));
        em(1, 2, 42); er(1, 1, 42); er(1, 2, 42); er(1, 3, 43);

        put(2, op_i(0, 1, 0, 1)); put(2, br(0, 1, 1, 8)); put(2, op_i(0, 2, 0, 9));
        put(2, op_i(0, 3, 0, 7)); put(2, br(1, 0, 0, 8)); put(2, op_i(0, 4, 0, 3));
        put(2, op_i(0, 5, 0, 11));
        er(2, 1, 1); er(2, 2, 0); er(2, 3, 7); er(2, 4, 3); er(2, 5, 11);

        put(3, lui(5, 'h80000)); put(3, op_i(5, 6, 5, 'h404)); put(3, op_i(5, 7, 5, 4));
        put(3, op_r(0, 2, 8, 5, 0)); put(3, op_r(0, 3, 9, 5, 0));
        er(3, 5, 32'h8000_0000); er(3, 6, 32'hF800_0000); er(3, 7, 32'h0800_0000);
        er(3, 8, 1); er(3, 9, 0);

        put(4, op_i(0, 0, 0, 5)); put(4, op_r(0, 0, 4, 0, 0)); put(4, op_i(0, 1, 0, 256));
        put(4, op_i(0, 2, 0, 77)); put(4, sw(2, 1, 4)); put(4, lw(3, 0, 7));
        er(4, 0, 0); er(4, 4, 0); em(4, 1, 77); er(4, 3, 77);

        put(5, op_i(0, 1, 0, -16));     put(5, op_i(0, 2, 0, 243));
        put(5, op_r(0, 7, 3, 1, 2));    put(5, op_r(0, 6, 4, 1, 2));
        put(5, op_r(0, 4, 5, 1, 2));    put(5, op_r(0, 1, 6, 2, 2));
        put(5, op_r(0, 5, 7, 1, 2));    put(5, op_r(32, 5, 8, 1, 2));
        put(5, op_r(0, 2, 9, 1, 2));    put(5, op_r(0, 3, 10, 1, 2));
        put(5, op_i(7, 11, 1, 'h7F));   put(5, op_i(6, 12, 2, -256));
        put(5, op_i(4, 13, 2, 'hFF));   put(5, op_i(2, 14, 1, -15));
        put(5, op_i(3, 15, 2, -1));     put(5, op_i(1, 16, 2, 4));
        put(5, op_i(5, 17, 1, 'h402));  put(5, op_r(32, 0, 18, 0, 1));
        put(5, 32'hFFFF_FFFF);          put(5, op_i(0, 19, 0, 1));
        put(5, op_i(0, 19, 0, 2));      put(5, op_r(0, 0, 20, 19, 0));
        er(5, 3, 32'h0000_00F0);  er(5, 4, 32'hFFFF_FFF3);  er(5, 5, 32'hFFFF_FF03);
        er(5, 6, 32'h0798_0000);  er(5, 7, 32'h0000_1FFF);  er(5, 8, 32'hFFFF_FFFF);
        er(5, 9, 1);              er(5, 10, 0);             er(5, 11, 32'h0000_0070);
        er(5, 12, 32'hFFFF_FFF3); er(5, 13, 32'h0000_000C); er(5, 14, 1);
        er(5, 15, 1);             er(5, 16, 32'h0000_0F30); er(5, 17, 32'hFFFF_FFFC);
        er(5, 18, 16);            er(5, 31, 0);             er(5, 20, 2);
    endtask

    task automatic load_prog(input int p);
        for (int i = 0; i < 32; i++) dut.if_stage.instruction_memory.ram[i] = pmem[p][i];
    endtask

    initial begin
        vec_t v;
        build();
        for (int i = 0; i < 64; i++) dut.mem_stage.data_memory.ram[i] = '0;
        dut.mem_stage.data_memory.ram[10] = 32'hDEAD_BEEF;
        dut.register_file.registers[7] = 32'h1234_5678;

        #2 rst = 1'b1;
        #1;
        check("reset x7", dut.register_file.registers[7], 32'h0);
        check("reset pc", 32'(dut.if_stage.pc_q), 32'h0);
        check("reset if_id", dut.if_id_instr_q, NOP);
        check("reset ex_mem_we", 32'(dut.ex_mem_mem_we_q), 32'h0);

        for (int p = 0; p < NPROG; p++) begin
            @(negedge clk);
            rst = 1'b1;
            load_prog(p);
            @(negedge clk);
            rst = 1'b0;
            foreach (vecs[k]) if (vecs[k].prog == p) sb.push_back(vecs[k]);
            repeat (200) @(posedge clk);
            @(negedge clk);
            while (sb.size() > 0) begin
                v = sb.pop_front();
                if (v.is_mem)
                    check($sformatf("p%0d dmem[%0d]", p, v.idx),
                          dut.mem_stage.data_memory.ram[v.idx], v.exp);
                else
                    check($sformatf("p%0d x%0d", p, v.idx),
                          dut.register_file.registers[v.idx], v.exp);
            end
        end

        // abort the store program before its SW reaches memory, then let it rerun
        @(negedge clk);
        rst = 1'b1;
        load_prog(1);
        dut.mem_stage.data_memory.ram[2] = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort dmem[2]", dut.mem_stage.data_memory.ram[2], 32'h0);
        check("abort x1", dut.register_file.registers[1], 32'h0);
        check("abort pc", 32'(dut.if_stage.pc_q), 32'h0);
        check("abort if_id", dut.if_id_instr_q, NOP);
        check("abort imem[0]", dut.if_stage.instruction_memory.ram[0], pmem[1][0]);
        check("abort dmem[10]", dut.mem_stage.data_memory.ram[10], 32'hDEAD_BEEF);
        rst = 1'b0;
        repeat (200) @(posedge clk);
        @(negedge clk);
        check("rerun dmem[2]", dut.mem_stage.data_memory.ram[2], 32'd42);
        check("rerun x3", dut.register_file.registers[3], 32'd43);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
